// File: rtl/vga_meter_overlay.sv
// Pixel-stream overlay that draws a horizontal power-meter bar with a white outline.
// The bar width is latched once per frame at vsync so it never tears; all outputs lag inputs by one clock.
module vga_meter_overlay #(
  parameter int unsigned BAR_X0  = 64,
  parameter int unsigned BAR_Y0  = 400,
  parameter int unsigned BAR_H   = 32,
  parameter int unsigned BAR_MAX = 512,
  parameter int unsigned THRESH  = 384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic [11:0] meter_value,
  input  logic        meter_valid,
  input  logic        overlay_en,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);

  localparam int unsigned CW = 12;
  localparam int unsigned AW = 13;
  localparam int unsigned PW = 24;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [AW-1:0] X_LO    = AW'(BAR_X0);
  localparam logic [AW-1:0] X_OL    = AW'(BAR_X0) - AW'(1);
  localparam logic [AW-1:0] X_OR    = AW'(BAR_X0 + BAR_MAX);
  localparam logic [AW-1:0] Y_LO    = AW'(BAR_Y0);
  localparam logic [AW-1:0] Y_OT    = AW'(BAR_Y0) - AW'(1);
  localparam logic [AW-1:0] Y_OB    = AW'(BAR_Y0 + BAR_H);
  localparam logic [AW-1:0] MAX_W   = AW'(BAR_MAX);
  localparam logic [AW-1:0] THR_W   = AW'(THRESH);

  localparam logic [PW-1:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [PW-1:0] RGB_RED   = 24'hFF0000;
  localparam logic [PW-1:0] RGB_GREEN = 24'h00FF00;

  logic          vs_q;
  logic          de_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic [CW-1:0] pend_q;
  logic [CW-1:0] width_q;
  logic          en_q;

  logic          vs_fall_c;
  logic          de_fall_c;
  logic [CW-1:0] pend_src_c;
  logic [CW-1:0] width_nxt_c;
  logic [AW-1:0] x_c;
  logic [AW-1:0] y_c;
  logic [AW-1:0] x_end_c;
  logic          in_bar_c;
  logic          outline_c;
  logic          alarm_c;
  logic [PW-1:0] rgb_c;

  assign vs_fall_c = vs_q & ~in_vs;
  assign de_fall_c = de_q & ~in_de;

  // A strobe coinciding with vsync bypasses the pending register straight into the frame width.
  assign pend_src_c  = meter_valid ? meter_value : pend_q;
  assign width_nxt_c = (AW'(pend_src_c) > MAX_W) ? CW'(BAR_MAX) : pend_src_c;

  assign x_c     = AW'(x_q);
  assign y_c     = AW'(y_q);
  assign x_end_c = X_LO + AW'(width_q);
  assign alarm_c = (AW'(width_q) >= THR_W);

  assign in_bar_c = in_de & en_q
                  & (y_c >= Y_LO) & (y_c < Y_OB)
                  & (x_c >= X_LO) & (x_c < x_end_c);

  assign outline_c = in_de & en_q
                   & ( (((y_c == Y_OT) | (y_c == Y_OB)) & (x_c >= X_OL) & (x_c <= X_OR))
                     | (((x_c == X_OL) | (x_c == X_OR)) & (y_c >= Y_OT) & (y_c <= Y_OB)) );

  // Pixel priority: outline, then bar, then upstream.
  always_comb begin
    rgb_c = {in_r, in_g, in_b};
    if (outline_c) begin
      rgb_c = RGB_WHITE;
    end else if (in_bar_c) begin
      rgb_c = alarm_c ? RGB_RED : RGB_GREEN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      vs_q <= in_vs;
      de_q <= in_de;
    end
  end

  // Raster position counters, both saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (!in_de) begin
        x_q <= '0;
      end else if (x_q != CNT_MAX) begin
        x_q <= x_q + CW'(1);
      end
      if (vs_fall_c) begin
        y_q <= '0;
      end else if (de_fall_c && (y_q != CNT_MAX)) begin
        y_q <= y_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      width_q <= '0;
      en_q    <= 1'b0;
    end else begin
      if (meter_valid) begin
        pend_q <= meter_value;
      end
      if (vs_fall_c) begin
        width_q <= width_nxt_c;
        en_q    <= overlay_en;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_hs <= 1'b1;
      out_vs <= 1'b1;
      out_de <= 1'b0;
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
    end else begin
      out_hs <= in_hs;
      out_vs <= in_vs;
      out_de <= in_de;
      {out_r, out_g, out_b} <= rgb_c;
    end
  end

endmodule

// File: tb/tb_vga_meter_overlay.sv
// Bench for vga_meter_overlay on a miniature raster, checked pixel-by-pixel against a frame-coordinate model.
module tb_vga_meter_overlay;

  localparam int X0 = 10, Y0 = 5, BH = 3, BMAX = 24, THR = 16;
  localparam int H_ACT = 40, H_TOT = 46, V_ACT = 12, V_TOT = 15, VS_LINE = 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_hs, in_vs, in_de;
  logic [7:0]  in_r, in_g, in_b;
  logic [11:0] meter_value;
  logic        meter_valid;
  logic        overlay_en;
  logic        out_hs, out_vs, out_de;
  logic [7:0]  out_r, out_g, out_b;

  always #5 clk = ~clk;

  vga_meter_overlay #(
    .BAR_X0(X0), .BAR_Y0(Y0), .BAR_H(BH), .BAR_MAX(BMAX), .THRESH(THR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .meter_value(meter_value), .meter_valid(meter_valid), .overlay_en(overlay_en),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_pend, m_w;
  bit m_en;
  int cnt_g, cnt_r, cnt_w;
  bit counting = 1'b0;
  bit rand_rgb = 1'b0;

  typedef struct {
    logic [11:0] mv;
    int          mode;   // 1: strobe mid-frame, 2: strobe on the vsync falling-edge cycle
    bit          en;
    int          g;
    int          r;
    int          w;
  } vec_t;

  vec_t tbl[8];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp_w(int v);
    return (v > BMAX) ? BMAX : v;
  endfunction

  // Expected colour from frame coordinates: outline is the ring between the box and its interior.
  function automatic logic [23:0] model_rgb(int line, int col, logic [23:0] up);
    bit in_box, in_inner, in_bar;
    if (!(line < V_ACT && col < H_ACT) || !m_en) return up;
    in_box   = (col >= X0 - 1) && (col <= X0 + BMAX) && (line >= Y0 - 1) && (line <= Y0 + BH);
    in_inner = (col >= X0) && (col < X0 + BMAX) && (line >= Y0) && (line < Y0 + BH);
    if (in_box && !in_inner) return 24'hFFFFFF;
    in_bar = (line >= Y0) && (line < Y0 + BH) && (col >= X0) && (col < X0 + m_w);
    if (in_bar) return (m_w >= THR) ? 24'hFF0000 : 24'h00FF00;
    return up;
  endfunction

  task automatic pixel(int line, int col, bit en, bit strobe, logic [11:0] mv);
    logic [23:0] up, exp_rgb;
    bit de, hs, vs, vs_fall;
    @(negedge clk);
    de = (line < V_ACT) && (col < H_ACT);
    hs = !((col >= H_ACT + 1) && (col <= H_ACT + 3));
    vs = (line != VS_LINE);
    up = rand_rgb ? 24'($urandom) : {8'(col), 8'(line), 8'h55};
    in_hs = hs; in_vs = vs; in_de = de;
    {in_r, in_g, in_b} = up;
    meter_valid = strobe; meter_value = mv; overlay_en = en;
    exp_rgb = model_rgb(line, col, up);
    vs_fall = (line == VS_LINE) && (col == 0);
    @(posedge clk); #1;
    check($sformatf("pix L%0d C%0d", line, col),
          32'({out_hs, out_vs, out_de, out_r, out_g, out_b}),
          32'({hs, vs, de, exp_rgb}));
    if (counting && out_de) begin
      case ({out_r, out_g, out_b})
        24'h00FF00: cnt_g++;
        24'hFF0000: cnt_r++;
        24'hFFFFFF: cnt_w++;
        default: ;
      endcase
    end
    if (strobe) m_pend = mv;
    if (vs_fall) begin
      m_w  = clamp_w(m_pend);
      m_en = en;
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("reset_async", 32'({out_hs, out_vs, out_de, out_r, out_g, out_b}), 32'({3'b110, 24'h0}));
    @(posedge clk); #1;
    check("reset_hold", 32'({out_hs, out_vs, out_de, out_r, out_g, out_b}), 32'({3'b110, 24'h0}));
    meter_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_pend = 0; m_w = 0; m_en = 1'b0;
  endtask

  task automatic run_frame(bit en, int s_line, int s_col, logic [11:0] s_val, bit rnd, int rst_line);
    for (int line = 0; line < V_TOT; line++) begin
      for (int col = 0; col < H_TOT; col++) begin
        bit st, en_c;
        logic [11:0] v;
        st = (line == s_line) && (col == s_col);
        v = s_val;
        en_c = en;
        if (rnd) begin
          if ($urandom_range(0, 39) == 0) begin
            st = 1'b1;
            v = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 30));
          end
          if ($urandom_range(0, 99) == 0) en_c = ~en;
        end
        pixel(line, col, en_c, st, v);
        if ((line == rst_line) && (col == 20)) do_reset();
      end
    end
  endtask

  initial begin
    tbl[0] = '{12'd7,    1, 1'b1, 21, 0,  58};
    tbl[1] = '{12'd4000, 1, 1'b1, 0,  72, 58};
    tbl[2] = '{12'd20,   2, 1'b1, 0,  60, 58};
    tbl[3] = '{12'd0,    1, 1'b1, 0,  0,  58};
    tbl[4] = '{12'd9,    1, 1'b0, 0,  0,  0};
    tbl[5] = '{12'd15,   2, 1'b1, 45, 0,  58};
    tbl[6] = '{12'd16,   1, 1'b1, 0,  48, 58};
    tbl[7] = '{12'd25,   2, 1'b1, 0,  72, 58};

    reset_n = 1'b0;
    in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b0;
    in_r = 8'h12; in_g = 8'h34; in_b = 8'h56;
    meter_value = 12'd0; meter_valid = 1'b0; overlay_en = 1'b0;
    m_pend = 0; m_w = 0; m_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({out_hs, out_vs, out_de, out_r, out_g, out_b}), 32'({3'b110, 24'h0}));
    @(negedge clk);
    reset_n = 1'b1;

    // Pass-through frame with the overlay disabled.
    run_frame(1'b0, -1, 0, 12'd0, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].mode == 1) run_frame(tbl[i].en, 3, 5, tbl[i].mv, 1'b0, -1);
      else                  run_frame(tbl[i].en, VS_LINE, 0, tbl[i].mv, 1'b0, -1);
      cnt_g = 0; cnt_r = 0; cnt_w = 0;
      counting = 1'b1;
      run_frame(tbl[i].en, -1, 0, 12'd0, 1'b0, -1);
      counting = 1'b0;
      check($sformatf("vec%0d green", i), 32'(cnt_g), 32'(tbl[i].g));
      check($sformatf("vec%0d red", i),   32'(cnt_r), 32'(tbl[i].r));
      check($sformatf("vec%0d white", i), 32'(cnt_w), 32'(tbl[i].w));
    end

    rand_rgb = 1'b1;
    for (int f = 0; f < 6; f++) begin
      run_frame(1'($urandom_range(0, 1)), -1, 0, 12'd0, 1'b1, -1);
    end
    rand_rgb = 1'b0;

    // Reset inside the bar, then a new reading after release: bar only returns after the next vsync.
    run_frame(1'b1, 2, 0, 12'd20, 1'b0, -1);
    run_frame(1'b1, 9, 3, 12'd12, 1'b0, 7);
    cnt_g = 0; cnt_r = 0; cnt_w = 0;
    counting = 1'b1;
    run_frame(1'b1, -1, 0, 12'd0, 1'b0, -1);
    counting = 1'b0;
    check("post_reset green", 32'(cnt_g), 32'd36);
    check("post_reset white", 32'(cnt_w), 32'd58);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_meter_overlay.md
VGA_METER_OVERLAY -- requirements
Module: vga_meter_overlay

Interface
REQ-001 Parameter BAR_X0, default 64: first active pixel column of the bar.
REQ-002 Parameter BAR_Y0, default 400: first active line of the bar.
REQ-003 Parameter BAR_H, default 32: bar height in lines.
REQ-004 Parameter BAR_MAX, default 512: maximum bar width in pixels.
REQ-005 Parameter THRESH, default 384: width at or above which the bar is drawn in alarm colour.
REQ-006 clk  input  1  pixel clock; the single clock of the block.
REQ-007 reset_n  input  1  reset; asynchronous, active-low.
REQ-008 in_hs, in_vs, in_de  input  1 each  sync and enable from the timing/pattern stage; syncs are active-low.
REQ-009 in_r, in_g, in_b  input  8 each  upstream pixel.
REQ-010 meter_value  input  12  power reading, used directly as bar width in pixels.
REQ-011 meter_valid  input  1  one-cycle strobe qualifying meter_value.
REQ-012 overlay_en  input  1  overlay enable.
REQ-013 out_hs, out_vs, out_de  output  1 each  in_hs, in_vs, in_de delayed by one cycle.
REQ-014 out_r, out_g, out_b  output  8 each  mixed pixel.

Function
REQ-015 Fixed latency: all outputs are registered, exactly 1 clk after the corresponding inputs.
REQ-016 Column counter x: clears to 0 on every cycle with in_de=0; increments by 1 on every cycle with in_de=1; saturates at 4095.
REQ-017 Line counter y: clears to 0 on an in_vs falling edge; increments by 1 on each in_de falling edge; saturates at 4095.
REQ-018 Edge detection uses registered copies of in_vs and in_de.
REQ-019 A strobe on meter_valid stores meter_value in a pending register; a later strobe overwrites it.
REQ-020 On an in_vs falling edge, the displayed width loads min(pending, BAR_MAX), and the displayed enable loads overlay_en.
REQ-021 Displayed width and displayed enable remain stable for the rest of the frame; no tearing is allowed.
REQ-022 If meter_valid and an in_vs falling edge occur on the same cycle, the pending register and the displayed width both take the new meter_value (bypass).
REQ-023 The current pixel is in the bar when all of the following hold:
- in_de=1;
- displayed enable=1;
- BAR_Y0 <= y < BAR_Y0+BAR_H;
- BAR_X0 <= x < BAR_X0+width.
REQ-024 Bar colour: {00,FF,00} if width < THRESH; otherwise {FF,00,00}.
REQ-025 Outline pixel: any in_de=1 pixel with displayed enable=1 that lies on either of these:
- row y=BAR_Y0-1 or y=BAR_Y0+BAR_H, with BAR_X0-1 <= x <= BAR_X0+BAR_MAX;
- column x=BAR_X0-1 or x=BAR_X0+BAR_MAX, with BAR_Y0-1 <= y <= BAR_Y0+BAR_H.
REQ-026 Outline colour is {FF,FF,FF}.
REQ-027 Output pixel priority: outline, then bar, then the upstream pixel.
REQ-028 Width 0 draws no bar pixels; the outline is still drawn.
REQ-029 When in_de=0, the output RGB is the upstream RGB passed through with no overlay.
REQ-030 Comparisons use 13-bit arithmetic so that BAR_X0+BAR_MAX and BAR_Y0+BAR_H do not wrap.

Reset
REQ-031 While reset_n=0, the following are held at 0:
- out_de and out_r/g/b;
- x and y;
- the pending register and displayed width;
- the displayed enable.
REQ-032 While reset_n=0, out_hs and out_vs are held at 1, and the registered in_vs/in_de copies are held at 1 and 0.
REQ-033 Reset asserted mid-frame: the first frame after release shows no bar until the next in_vs falling edge.

Verification
REQ-034 Pass-through: overlay_en=0, ramp on in_r with 1024x768 timing -> outputs equal inputs delayed by 1 clk, all frames.
REQ-035 Bar draw: overlay_en=1, meter_value=100 strobed mid-frame -> no bar that frame.
- Next frame, lines 400..431 at columns 64..163 are {00,FF,00}.
- Column 164 shows the upstream pixel.
REQ-036 Clamp/alarm: meter_value=4000 -> next frame, bar columns 64..575 are {FF,00,00}; outline white at column 576 and at lines 399 and 432.
REQ-037 Simultaneous event: meter_valid with meter_value=200 on the exact in_vs falling-edge cycle -> bar width 200 in that same frame.
REQ-038 Width zero: meter_value=0 -> only the outline is drawn; the interior shows the upstream pixels.
REQ-039 Async reset at line 410 -> on the same clock edge, outputs read hs/vs=1, de=0, RGB=0; after release, no bar until the next vsync.
